// File: rtl/wb_irq_gen_pkg.sv
// Shared constants for the Wishbone interrupt generator: register offsets and FSM states.
package wb_irq_gen_pkg;

    localparam int unsigned WB_DW = 32;

    // Word offsets decoded from wb_adr_i[3:2]; software headers use the same values.
    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_HOLDOFF = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } irq_state_e;

endpackage

// File: rtl/wb_irq_gen_sync.sv
// Per-source 2-flop synchroniser, one-cycle delay flop and edge/level set detection.
module wb_irq_gen_sync
    import wb_irq_gen_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_src,
    input  logic [W-1:0] i_mode,
    output logic [W-1:0] o_set_c
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    logic [W-1:0] r_s2_d;

    // Synchronise raw sources and keep the previous synchronised value for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s2_d <= '0;
        end else begin
            r_s1   <= i_src;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    // Edge mode sets on a rising transition, level mode sets while high
    assign o_set_c = (i_mode & r_s2 & ~r_s2_d) | (~i_mode & r_s2);

endmodule

// File: rtl/wb_irq_gen.sv
// Wishbone interrupt generator: pending/mask/mode/holdoff registers and active-low IRQ FSM.
module wb_irq_gen
    import wb_irq_gen_pkg::*;
#(
    parameter int unsigned SOURCES   = 8,
    parameter int unsigned HOLDOFF_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    input  logic               wb_we_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    output logic               wb_ack_o,
    input  logic [SOURCES-1:0] src_i,
    output logic               irq_n_o
);

    logic [SOURCES-1:0]   r_pending;
    logic [SOURCES-1:0]   r_mask;
    logic [SOURCES-1:0]   r_mode;
    logic [HOLDOFF_W-1:0] r_holdoff;
    logic [HOLDOFF_W-1:0] r_cnt;
    logic                 r_ack;
    logic [WB_DW-1:0]     r_dat;
    logic                 r_irq_n;
    irq_state_e           r_state;

    logic                 w_acc;
    logic                 w_wr;
    logic                 w_rd;
    logic [1:0]           w_reg;
    logic [SOURCES-1:0]   w_set;
    logic [SOURCES-1:0]   w_clr;
    logic [WB_DW-1:0]     w_rdata;
    logic                 w_req;
    irq_state_e           w_next;
    logic                 w_unused_bits;

    assign w_acc = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_wr  = w_acc & wb_we_i;
    assign w_rd  = w_acc & ~wb_we_i;
    assign w_reg = wb_adr_i[3:2];
    assign w_clr = (w_wr && (w_reg == REG_STATUS)) ? wb_dat_i[SOURCES-1:0] : '0;
    assign w_req = |(r_pending & r_mask);

    // Byte selects and non-decoded address bits are intentionally ignored
    assign w_unused_bits = &{1'b0, wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i};

    wb_irq_gen_sync #(.W(SOURCES)) u_sync (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_src   (src_i),
        .i_mode  (r_mode),
        .o_set_c (w_set)
    );

    // Control registers written on the accepting edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mask    <= '0;
            r_mode    <= '0;
            r_holdoff <= '0;
        end else if (w_wr) begin
            case (w_reg)
                REG_MASK:    r_mask    <= wb_dat_i[SOURCES-1:0];
                REG_MODE:    r_mode    <= wb_dat_i[SOURCES-1:0];
                REG_HOLDOFF: r_holdoff <= wb_dat_i[HOLDOFF_W-1:0];
                default:     ;
            endcase
        end
    end

    // Pending latch: a fresh set wins over a simultaneous write-1-to-clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Read data selection
    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_STATUS:  w_rdata = WB_DW'(r_pending);
            REG_MASK:    w_rdata = WB_DW'(r_mask);
            REG_MODE:    w_rdata = WB_DW'(r_mode);
            REG_HOLDOFF: w_rdata = WB_DW'(r_holdoff);
            default:     w_rdata = '0;
        endcase
    end

    // Single-cycle Wishbone ack and registered read data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_rd) begin
                r_dat <= w_rdata;
            end
        end
    end

    // Interrupt FSM next state; requests are ignored while the holdoff runs
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (!w_req) begin
                    w_next = (r_holdoff == '0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (r_cnt <= HOLDOFF_W'(1)) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Interrupt FSM state, holdoff counter and registered active-low output
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_irq_n <= 1'b1;
        end else begin
            r_state <= w_next;
            r_irq_n <= ~(w_next == ST_ASSERT);
            if ((r_state == ST_ASSERT) && (w_next == ST_HOLDOFF)) begin
                r_cnt <= r_holdoff;
            end else if ((r_state == ST_HOLDOFF) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - HOLDOFF_W'(1);
            end
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign irq_n_o  = r_irq_n;

endmodule

// File: tb/tb_wb_irq_gen.sv
// Directed bench for wb_irq_gen: read scoreboard queue plus interrupt timing checks.
module tb_wb_irq_gen;
    import wb_irq_gen_pkg::*;

    localparam int unsigned SOURCES   = 8;
    localparam int unsigned HOLDOFF_W = 16;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [31:0]        wb_adr_i;
    logic [31:0]        wb_dat_i;
    logic [31:0]        wb_dat_o;
    logic               wb_we_i;
    logic [3:0]         wb_sel_i;
    logic               wb_stb_i;
    logic               wb_cyc_i;
    logic               wb_ack_o;
    logic [SOURCES-1:0] src_i;
    logic               irq_n_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    wb_irq_gen #(.SOURCES(SOURCES), .HOLDOFF_W(HOLDOFF_W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_ack_o (wb_ack_o),
        .src_i    (src_i),
        .irq_n_o  (irq_n_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // One bus access; returns at the falling edge right after the ack edge
    task automatic wb_xfer(input logic we, input logic [1:0] radr,
                           input logic [31:0] data, input logic [31:0] rd_exp,
                           input string tag);
        logic got;
        logic [31:0] e;
        if (!we) exp_q.push_back(rd_exp);
        @(negedge clk_i);
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = {28'd0, radr, 2'b00};
        wb_dat_i = data;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk_i);
            if (wb_ack_o) got = 1'b1;
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        check({tag, "_ack"}, 32'(got), 32'd1);
        if (!we) begin
            e = exp_q.pop_front();
            if (got) check(tag, wb_dat_o, e);
        end
    endtask

    task automatic wr(input logic [1:0] radr, input logic [31:0] data);
        wb_xfer(1'b1, radr, data, 32'd0, "wr");
    endtask

    task automatic rd(input logic [1:0] radr, input logic [31:0] exp, input string tag);
        wb_xfer(1'b0, radr, 32'd0, exp, tag);
    endtask

    task automatic wait_irq(input logic exp, input int max, input string tag);
        int n = 0;
        while (irq_n_o !== exp && n < max) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, 32'(irq_n_o), 32'(exp));
    endtask

    initial begin
        int gap;
        rst_i    = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'hf;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        src_i    = '0;

        // Reset state
        tick(3);
        check("rst_irq", 32'(irq_n_o), 32'd1);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        rst_i = 1'b0;
        rd(REG_STATUS,  32'd0, "rst_status");
        rd(REG_MASK,    32'd0, "rst_mask");
        rd(REG_MODE,    32'd0, "rst_mode");
        rd(REG_HOLDOFF, 32'd0, "rst_holdoff");
        check("rst_irq_after", 32'(irq_n_o), 32'd1);

        // Edge source 0: latency and W1C clear
        wr(REG_MASK, 32'h01);
        wr(REG_MODE, 32'h01);
        @(negedge clk_i);
        src_i[0] = 1'b1;
        @(negedge clk_i);
        src_i[0] = 1'b0;
        check("lat_e0", 32'(irq_n_o), 32'd1);
        @(negedge clk_i);
        check("lat_e1", 32'(irq_n_o), 32'd1);
        @(negedge clk_i);
        check("lat_e2", 32'(irq_n_o), 32'd1);
        @(negedge clk_i);
        check("lat_e3", 32'(irq_n_o), 32'd0);
        rd(REG_STATUS, 32'h01, "edge_status");
        wr(REG_STATUS, 32'h01);
        check("clr_at_ack", 32'(irq_n_o), 32'd0);
        @(negedge clk_i);
        check("clr_ack_p1", 32'(irq_n_o), 32'd1);
        check("ack_one_cycle", 32'(wb_ack_o), 32'd0);
        rd(REG_STATUS, 32'h00, "edge_status_clr");

        // Level source 2: held source cannot be cleared
        wr(REG_MODE, 32'h00);
        wr(REG_MASK, 32'h04);
        src_i[2] = 1'b1;
        tick(4);
        check("lvl_irq", 32'(irq_n_o), 32'd0);
        wr(REG_STATUS, 32'h04);
        rd(REG_STATUS, 32'h04, "lvl_status_held");
        check("lvl_irq_held", 32'(irq_n_o), 32'd0);
        src_i[2] = 1'b0;
        tick(4);
        wr(REG_STATUS, 32'h04);
        check("lvl_clr_at_ack", 32'(irq_n_o), 32'd0);
        @(negedge clk_i);
        check("lvl_clr_ack_p1", 32'(irq_n_o), 32'd1);
        rd(REG_STATUS, 32'h00, "lvl_status_clr");

        // Holdoff of 5: gap of exactly 6 cycles
        wr(REG_HOLDOFF, 32'd5);
        wr(REG_MODE, 32'h02);
        wr(REG_MASK, 32'h02);
        @(negedge clk_i);
        src_i[1] = 1'b1;
        @(negedge clk_i);
        src_i[1] = 1'b0;
        wait_irq(1'b0, 10, "ho_first");
        wr(REG_STATUS, 32'h02);
        check("ho_clr_at_ack", 32'(irq_n_o), 32'd0);
        src_i[1] = 1'b1;
        @(negedge clk_i);
        src_i[1] = 1'b0;
        gap = 0;
        while (irq_n_o === 1'b1 && gap < 20) begin
            gap++;
            @(negedge clk_i);
        end
        check("ho_gap", 32'(gap), 32'd6);
        check("ho_refire", 32'(irq_n_o), 32'd0);
        rd(REG_HOLDOFF, 32'd5, "ho_reg");

        // Masked pending source 7, then unmask
        wr(REG_MASK, 32'h00);
        wr(REG_STATUS, 32'h02);
        wr(REG_HOLDOFF, 32'd0);
        tick(10);
        wr(REG_MODE, 32'h80);
        @(negedge clk_i);
        src_i[7] = 1'b1;
        @(negedge clk_i);
        src_i[7] = 1'b0;
        tick(6);
        check("masked_irq", 32'(irq_n_o), 32'd1);
        rd(REG_STATUS, 32'h80, "masked_status");
        wr(REG_MASK, 32'h80);
        check("unmask_at_ack", 32'(irq_n_o), 32'd1);
        @(negedge clk_i);
        check("unmask_ack_p1", 32'(irq_n_o), 32'd0);

        // Asynchronous reset while asserted
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1 check("arst_assert_irq", 32'(irq_n_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd(REG_STATUS,  32'd0, "arst1_status");
        rd(REG_MASK,    32'd0, "arst1_mask");
        rd(REG_MODE,    32'd0, "arst1_mode");
        rd(REG_HOLDOFF, 32'd0, "arst1_holdoff");

        // Asynchronous reset mid-holdoff
        wr(REG_HOLDOFF, 32'd20);
        wr(REG_MODE, 32'h01);
        wr(REG_MASK, 32'h01);
        @(negedge clk_i);
        src_i[0] = 1'b1;
        @(negedge clk_i);
        src_i[0] = 1'b0;
        wait_irq(1'b0, 10, "arst2_fire");
        wr(REG_STATUS, 32'h01);
        @(negedge clk_i);
        check("arst2_in_holdoff", 32'(irq_n_o), 32'd1);
        tick(3);
        #2 rst_i = 1'b1;
        #1 check("arst_holdoff_irq", 32'(irq_n_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd(REG_STATUS,  32'd0, "arst2_status");
        rd(REG_MASK,    32'd0, "arst2_mask");
        rd(REG_MODE,    32'd0, "arst2_mode");
        rd(REG_HOLDOFF, 32'd0, "arst2_holdoff");
        tick(25);
        check("arst2_irq_idle", 32'(irq_n_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
